if_queue: RTL and testbench

Parametrised fetch-to-decode instruction queue that replaces the single-entry IF/ID pipeline register. It buffers up to DEPTH fetched instructions, each with its PC and branch-prediction bit, between the fetch stage and the decode stage using valid/ready handshakes. Flush empties the queue in one cycle, and a global CPU enable freezes it. It sits directly after instruction fetch and feeds the decoder.

---
 rtl/if_queue.sv | 118 +++++++++++
 tb/tb_if_queue.sv | 321 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/if_queue.sv
// if_queue: fetch-to-decode instruction queue.
//
// Buffers up to DEPTH fetched instructions {pc, insn, predicted-taken bit}
// between the fetch and decode stages using valid/ready handshakes.
//
// Ports:
//   clk, rst_n          clock (rising edge) and asynchronous active-low reset
//   cpu_en              global enable; 0 freezes the queue (no push, no pop)
//   if_flush            drop all entries; takes effect even while cpu_en = 0
//   in_valid/in_ready   fetch-side handshake
//   in_pc/in_insn/in_predt_br_taken     entry presented by fetch
//   out_valid/out_ready decode-side handshake
//   out_pc/out_insn/out_predt_br_taken  head entry, zeroed while out_valid = 0
//   count               current occupancy (0..DEPTH)
//
// in_ready and out_valid depend only on cpu_en and registered state, so no
// combinational path exists from in_valid or out_ready to the handshakes.
module if_queue #(
  parameter int unsigned DEPTH  = 4,
  parameter int unsigned PC_W   = 32,
  parameter int unsigned INSN_W = 32
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     cpu_en,
  input  logic                     if_flush,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [PC_W-1:0]          in_pc,
  input  logic [INSN_W-1:0]        in_insn,
  input  logic                     in_predt_br_taken,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [PC_W-1:0]          out_pc,
  output logic [INSN_W-1:0]        out_insn,
  output logic                     out_predt_br_taken,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;
  localparam logic [CW-1:0] FullCount = CW'(DEPTH);

  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;

  // Storage has no reset: flush and reset only clear pointers and count.
  logic [PC_W-1:0]   pc_mem    [DEPTH];
  logic [INSN_W-1:0] insn_mem  [DEPTH];
  logic              predt_mem [DEPTH];

  logic push;
  logic pop;

  // Readiness does not anticipate a same-cycle pop: a full queue refuses pushes.
  assign in_ready  = cpu_en & (count_q != FullCount);
  assign out_valid = cpu_en & (count_q != '0);

  // in_ready / out_valid already include cpu_en.
  assign push = in_valid & in_ready & ~if_flush;
  assign pop  = out_valid & out_ready & ~if_flush;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (if_flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      // DEPTH is a power of two, so natural overflow wraps modulo DEPTH.
      if (push) wr_ptr_d = wr_ptr_q + AW'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
      unique case ({push, pop})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      pc_mem[wr_ptr_q]    <= in_pc;
      insn_mem[wr_ptr_q]  <= in_insn;
      predt_mem[wr_ptr_q] <= in_predt_br_taken;
    end
  end

  // Decode sees an all-zero (NOP-equivalent) entry whenever the head is invalid.
  always_comb begin
    out_pc             = '0;
    out_insn           = '0;
    out_predt_br_taken = 1'b0;
    if (out_valid) begin
      out_pc             = pc_mem[rd_ptr_q];
      out_insn           = insn_mem[rd_ptr_q];
      out_predt_br_taken = predt_mem[rd_ptr_q];
    end
  end

  assign count = count_q;

endmodule

// File: tb/tb_if_queue.sv
// Self-checking bench for if_queue: directed scenarios plus a randomized run,
// all compared against a queue-based reference model of the FIFO.
module tb_if_queue;

  localparam int DEPTH = 4;
  localparam int CW    = $clog2(DEPTH) + 1;

  logic              clk;
  logic              rst_n;
  logic              cpu_en;
  logic              if_flush;
  logic              in_valid;
  logic              in_ready;
  logic [31:0]       in_pc;
  logic [31:0]       in_insn;
  logic              in_predt_br_taken;
  logic              out_valid;
  logic              out_ready;
  logic [31:0]       out_pc;
  logic [31:0]       out_insn;
  logic              out_predt_br_taken;
  logic [CW-1:0]     count;

  int checks;
  int errors;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] insn;
    logic        predt;
  } ent_t;

  ent_t mq[$];

  if_queue #(.DEPTH(DEPTH), .PC_W(32), .INSN_W(32)) dut (
    .clk                (clk),
    .rst_n              (rst_n),
    .cpu_en             (cpu_en),
    .if_flush           (if_flush),
    .in_valid           (in_valid),
    .in_ready           (in_ready),
    .in_pc              (in_pc),
    .in_insn            (in_insn),
    .in_predt_br_taken  (in_predt_br_taken),
    .out_valid          (out_valid),
    .out_ready          (out_ready),
    .out_pc             (out_pc),
    .out_insn           (out_insn),
    .out_predt_br_taken (out_predt_br_taken),
    .count              (count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model views.
  function automatic logic m_valid();
    return cpu_en && (mq.size() != 0);
  endfunction

  function automatic logic m_ready();
    return cpu_en && (mq.size() < DEPTH);
  endfunction

  function automatic logic [CW-1:0] m_count();
    return CW'(mq.size());
  endfunction

  function automatic ent_t m_head();
    ent_t z;
    z = '0;
    if (m_valid()) z = mq[0];
    return z;
  endfunction

  task automatic drive(input logic v, input logic [31:0] pc, input logic r);
    in_valid          = v;
    in_pc             = pc;
    in_insn           = $urandom;
    in_predt_br_taken = 1'($urandom_range(0, 1));
    out_ready         = r;
    #1;
  endtask

  // One clock edge; the model applies the same transfer rules afterwards.
  task automatic tick();
    bit   push;
    bit   pop;
    ent_t e;
    push    = cpu_en && in_valid && m_ready() && !if_flush;
    pop     = cpu_en && m_valid() && out_ready && !if_flush;
    e.pc    = in_pc;
    e.insn  = in_insn;
    e.predt = in_predt_br_taken;
    @(posedge clk);
    if (if_flush) begin
      mq.delete();
    end else begin
      if (pop) void'(mq.pop_front());
      if (push) mq.push_back(e);
    end
    #1;
  endtask

  task automatic test_reset();
    checks++;
    if (count !== '0) begin
      errors++; $display("FAIL reset_count: got %0d want 0", count);
    end
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      errors++; $display("FAIL reset_hs: got v=%b r=%b want v=0 r=1", out_valid, in_ready);
    end
    checks++;
    if (out_pc !== 32'h0 || out_insn !== 32'h0 || out_predt_br_taken !== 1'b0) begin
      errors++; $display("FAIL reset_out: got pc=%h insn=%h p=%b want zeros",
                         out_pc, out_insn, out_predt_br_taken);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_fill();
    for (int k = 0; k < 4; k++) begin
      drive(1'b1, 32'(4 * k), 1'b0);
      tick();
    end
    checks++;
    if (count !== CW'(4) || in_ready !== 1'b0) begin
      errors++; $display("FAIL fill_full: got count=%0d rdy=%b want 4 0", count, in_ready);
    end
    drive(1'b1, 32'h10, 1'b0);
    tick();
    checks++;
    if (count !== CW'(4) || out_pc !== 32'h0) begin
      errors++; $display("FAIL fill_fifth: got count=%0d pc=%h want 4 00", count, out_pc);
    end
  endtask

  task automatic test_drain();
    ent_t h;
    for (int k = 0; k < 4; k++) begin
      drive(1'b0, 32'h0, 1'b1);
      h = m_head();
      checks++;
      if (out_valid !== 1'b1 || out_pc !== 32'(4 * k) || out_insn !== h.insn
          || out_predt_br_taken !== h.predt) begin
        errors++; $display("FAIL drain_%0d: got v=%b pc=%h insn=%h p=%b want 1 %h %h %b",
                           k, out_valid, out_pc, out_insn, out_predt_br_taken,
                           32'(4 * k), h.insn, h.predt);
      end
      tick();
    end
    checks++;
    if (out_valid !== 1'b0 || out_insn !== 32'h0 || count !== '0) begin
      errors++; $display("FAIL drain_empty: got v=%b insn=%h count=%0d want 0 0 0",
                         out_valid, out_insn, count);
    end
  endtask

  task automatic test_stream();
    drive(1'b1, 32'h100, 1'b0);
    tick();
    for (int k = 1; k <= 10; k++) begin
      drive(1'b1, 32'h100 + 32'(4 * k), 1'b1);
      checks++;
      if (count !== CW'(1) || out_pc !== 32'h100 + 32'(4 * (k - 1))) begin
        errors++; $display("FAIL stream_%0d: got count=%0d pc=%h want 1 %h",
                           k, count, out_pc, 32'h100 + 32'(4 * (k - 1)));
      end
      tick();
    end
    drive(1'b0, 32'h0, 1'b1);
    tick();
    checks++;
    if (count !== '0 || out_valid !== 1'b0) begin
      errors++; $display("FAIL stream_end: got count=%0d v=%b want 0 0", count, out_valid);
    end
  endtask

  task automatic test_flush();
    for (int k = 0; k < 3; k++) begin
      drive(1'b1, 32'h180 + 32'(4 * k), 1'b0);
      tick();
    end
    drive(1'b1, 32'h1f0, 1'b1);
    if_flush = 1'b1;
    tick();
    if_flush = 1'b0;
    #1;
    checks++;
    if (count !== '0 || out_valid !== 1'b0) begin
      errors++; $display("FAIL flush_clear: got count=%0d v=%b want 0 0", count, out_valid);
    end
    drive(1'b1, 32'h200, 1'b0);
    tick();
    checks++;
    if (count !== CW'(1) || out_valid !== 1'b1 || out_pc !== 32'h200) begin
      errors++; $display("FAIL flush_next: got count=%0d v=%b pc=%h want 1 1 200",
                         count, out_valid, out_pc);
    end
    drive(1'b0, 32'h0, 1'b1);
    tick();
  endtask

  task automatic test_freeze();
    ent_t h;
    drive(1'b1, 32'h300, 1'b0);
    tick();
    drive(1'b1, 32'h304, 1'b0);
    tick();
    h = mq[0];
    cpu_en = 1'b0;
    for (int k = 0; k < 3; k++) begin
      drive(1'b1, 32'h308, 1'b1);
      checks++;
      if (count !== CW'(2) || in_ready !== 1'b0 || out_valid !== 1'b0 || out_pc !== 32'h0) begin
        errors++; $display("FAIL freeze_%0d: got count=%0d rdy=%b v=%b pc=%h want 2 0 0 0",
                           k, count, in_ready, out_valid, out_pc);
      end
      tick();
    end
    cpu_en = 1'b1;
    drive(1'b0, 32'h0, 1'b0);
    checks++;
    if (out_valid !== 1'b1 || out_pc !== 32'h300 || out_insn !== h.insn
        || out_predt_br_taken !== h.predt || count !== CW'(2)) begin
      errors++; $display("FAIL freeze_resume: got v=%b pc=%h insn=%h cnt=%0d want 1 300 %h 2",
                         out_valid, out_pc, out_insn, count, h.insn);
    end
    // Flush must still act while frozen.
    cpu_en   = 1'b0;
    if_flush = 1'b1;
    tick();
    if_flush = 1'b0;
    cpu_en   = 1'b1;
    #1;
    checks++;
    if (count !== '0 || out_valid !== 1'b0) begin
      errors++; $display("FAIL freeze_flush: got count=%0d v=%b want 0 0", count, out_valid);
    end
  endtask

  task automatic test_async_reset();
    for (int k = 0; k < 3; k++) begin
      drive(1'b1, 32'h380 + 32'(4 * k), 1'b0);
      in_predt_br_taken = 1'b1;
      #1;
      tick();
    end
    drive(1'b0, 32'h0, 1'b0);
    #2;
    rst_n = 1'b0;
    mq.delete();
    #1;
    checks++;
    if (out_valid !== 1'b0 || count !== '0 || out_predt_br_taken !== 1'b0
        || in_ready !== 1'b1) begin
      errors++; $display("FAIL async_reset: got v=%b cnt=%0d p=%b rdy=%b want 0 0 0 1",
                         out_valid, count, out_predt_br_taken, in_ready);
    end
    @(negedge clk);
    rst_n = 1'b1;
    drive(1'b1, 32'h400, 1'b0);
    tick();
    checks++;
    if (count !== CW'(1) || out_pc !== 32'h400) begin
      errors++; $display("FAIL reset_push: got cnt=%0d pc=%h want 1 400", count, out_pc);
    end
    drive(1'b0, 32'h0, 1'b1);
    tick();
  endtask

  task automatic test_random();
    ent_t h;
    for (int n = 0; n < 400; n++) begin
      cpu_en   = ($urandom_range(0, 9) != 0);
      if_flush = ($urandom_range(0, 29) == 0);
      drive(1'($urandom_range(0, 1)), $urandom, 1'($urandom_range(0, 2) != 0));
      h = m_head();
      checks++;
      if (count !== m_count() || in_ready !== m_ready() || out_valid !== m_valid()
          || out_pc !== h.pc || out_insn !== h.insn || out_predt_br_taken !== h.predt) begin
        errors++;
        $display("FAIL rand_%0d: got cnt=%0d rdy=%b v=%b pc=%h insn=%h p=%b want %0d %b %b %h %h %b",
                 n, count, in_ready, out_valid, out_pc, out_insn, out_predt_br_taken,
                 m_count(), m_ready(), m_valid(), h.pc, h.insn, h.predt);
      end
      tick();
    end
    if_flush = 1'b0;
    cpu_en   = 1'b1;
  endtask

  initial begin
    checks            = 0;
    errors            = 0;
    rst_n             = 1'b0;
    cpu_en            = 1'b1;
    if_flush          = 1'b0;
    in_valid          = 1'b0;
    in_pc             = '0;
    in_insn           = '0;
    in_predt_br_taken = 1'b0;
    out_ready         = 1'b0;
    #2;
    test_reset();
    test_fill();
    test_drain();
    test_stream();
    test_flush();
    test_freeze();
    test_async_reset();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
